// File: rtl/instr_sequencer_if.sv
// RAM and display side of the instruction sequencer: two registered read ports,
// one write port, the clear-all strobe and the display outputs.
interface instr_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_en;
  logic              disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_value;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_en,
           disp_valid, disp_addr, disp_value,
    input  rd_data1, rd_data2
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_en,
           disp_valid, disp_addr, disp_value,
    output rd_data1, rd_data2
  );
endinterface

// File: rtl/instr_sequencer.sv
// Mini-CPU front end: synchronizes the send button, latches one instruction per
// press and sequences RAM read, ALU execute and a single write/clear/display strobe.
//
// state | meaning
// IDLE  | waiting for an accepted send rise
// READ  | RAM addresses driven, data returns next cycle
// EXEC  | ALU result and overflow captured
// WRITE | one strobe plus done, then back to IDLE
module instr_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send,
  input  logic [15:0]         instr,
  instr_sequencer_if.master   bus,
  output logic                ovf,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_ADD   = 3'b001,
    OP_ADDI  = 3'b010,
    OP_SUB   = 3'b011,
    OP_SUBI  = 3'b100,
    OP_MUL   = 3'b101,
    OP_CLEAR = 3'b110,
    OP_DISP  = 3'b111
  } op_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   send_rise;

  logic [15:0]       instr_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] disp_value_q;
  logic              ovf_q;

  op_t               op, op_in;
  logic [ADDR_W-1:0] fld_a, fld_b, fld_c;
  logic [DATA_W-1:0] imm5_ext, imm9_ext;
  logic              is_alu;

  logic signed [DATA_W-1:0]   d1, d2, opnd;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          alu_res;
  logic                       alu_ovf;

  assign send_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

  assign op_in    = op_t'(instr[15:13]);
  assign op       = op_t'(instr_q[15:13]);
  assign fld_a    = instr_q[12:9];
  assign fld_b    = instr_q[8:5];
  assign fld_c    = instr_q[4:1];
  assign imm5_ext = {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]};
  assign imm9_ext = {{(DATA_W-9){instr_q[8]}}, instr_q[8:0]};
  assign is_alu   = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
                    (op == OP_SUBI) || (op == OP_MUL);

  always_comb begin
    d1      = signed'(bus.rd_data1);
    d2      = signed'(bus.rd_data2);
    opnd    = ((op == OP_ADD) || (op == OP_SUB)) ? d2 : signed'(imm5_ext);
    prod    = d1 * opnd;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_res = d1 + opnd;
        alu_ovf = (d1[DATA_W-1] == opnd[DATA_W-1]) && (alu_res[DATA_W-1] != d1[DATA_W-1]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = d1 - opnd;
        alu_ovf = (d1[DATA_W-1] != opnd[DATA_W-1]) && (alu_res[DATA_W-1] != d1[DATA_W-1]);
      end
      OP_MUL: begin
        alu_res = prod[DATA_W-1:0];
        // product fits only if the upper half is a pure sign extension
        alu_ovf = prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[DATA_W-1]}};
      end
      OP_DISP: alu_res = bus.rd_data1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync_q       <= '0;
      sync_prev    <= 1'b0;
      instr_q      <= '0;
      res_q        <= '0;
      disp_value_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], send};
      sync_prev <= sync_q[SYNC_STAGES-1];
      if ((state == IDLE) && send_rise) begin
        instr_q <= instr;
      end
      if (state == EXEC) begin
        res_q <= alu_res;
        if (is_alu) begin
          ovf_q <= alu_ovf;
        end
        if (op == OP_DISP) begin
          disp_value_q <= alu_res;
        end
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.rd_addr1   = '0;
    bus.rd_addr2   = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.clr_en     = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_addr  = '0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (send_rise) begin
          state_nxt = ((op_in == OP_LOAD) || (op_in == OP_CLEAR)) ? WRITE : READ;
        end
      end
      READ: begin
        bus.rd_addr1 = (op == OP_DISP) ? fld_a : fld_b;
        bus.rd_addr2 = fld_c;
        state_nxt    = EXEC;
      end
      EXEC: state_nxt = WRITE;
      WRITE: begin
        done = 1'b1;
        case (op)
          OP_LOAD: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = fld_a;
            bus.wr_data = imm9_ext;
          end
          OP_CLEAR: bus.clr_en = 1'b1;
          OP_DISP: begin
            bus.disp_valid = 1'b1;
            bus.disp_addr  = fld_a;
          end
          default: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = fld_a;
            bus.wr_data = res_q;
          end
        endcase
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.disp_value = disp_value_q;
  assign ovf            = ovf_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: behavioural RAM plus an arithmetic
// reference model of the instruction set, directed plan cases then random ones.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        send;
  logic [15:0] instr;
  logic        ovf;
  logic        busy;
  logic        done;

  instr_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  instr_sequencer #(.DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .send  (send),
    .instr (instr),
    .bus   (bus.master),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram [16];
  logic        bd_en;
  logic [3:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    bus.rd_data1 <= ram[bus.rd_addr1];
    bus.rd_data2 <= ram[bus.rd_addr2];
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (bus.clr_en) begin
      for (int i = 0; i < 16; i++) ram[i] <= 16'h0;
    end else if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_strobe = 0;

  always @(negedge clk) begin
    if (done) n_done++;
    if (bus.wr_en || bus.clr_en || bus.disp_valid) n_strobe++;
  end

  logic        m_ovf;
  logic [15:0] m_disp;
  logic [15:0] last_data;
  logic        last_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sxn(input logic [15:0] v, input int w);
    int x;
    x = int'(v) & ((1 << w) - 1);
    if (x >= (1 << (w - 1))) x -= (1 << w);
    return x;
  endfunction

  task automatic ram_poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input bit pulse_in, input int hold);
    logic [2:0]  op;
    logic [3:0]  a, b, c;
    int          s1, s2, s5, s9, r, kind, lat, t, done0, strobe0;
    bit          upd, pulse;
    logic [15:0] exp_data;
    logic        orv;
    op = ins[15:13]; a = ins[12:9]; b = ins[8:5]; c = ins[4:1];
    s5 = sxn(ins, 5);
    s9 = sxn(ins, 9);
    s1 = sxn(ram[(op == 3'd7) ? a : b], 16);
    s2 = sxn(ram[c], 16);
    kind = 0; lat = 2; r = 0; upd = 1'b1;
    case (op)
      3'd0: begin lat = 0; r = s9; upd = 1'b0; end
      3'd1: r = s1 + s2;
      3'd2: r = s1 + s5;
      3'd3: r = s1 - s2;
      3'd4: r = s1 - s5;
      3'd5: r = s1 * s5;
      3'd6: begin kind = 1; lat = 0; upd = 1'b0; end
      default: begin kind = 2; r = s1; upd = 1'b0; end
    endcase
    exp_data = 16'(r);
    if (upd) m_ovf = (r > 32767) || (r < -32768);
    if (kind == 2) m_disp = exp_data;
    pulse = pulse_in && (lat == 2);
    done0 = n_done; strobe0 = n_strobe;

    @(negedge clk);
    instr = ins; send = 1'b1;
    if (pulse) begin
      @(negedge clk); send = 1'b0;
      @(negedge clk); send = 1'b1;
    end
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk); t++;
    end
    chk("accept", 32'(busy), 32'd1);
    if (busy) begin
      for (int k = 0; k <= lat + 1; k++) begin
        if (k < lat) begin
          chk("busy_pre", 32'(busy), 32'd1);
          chk("strobe_early", 32'({bus.wr_en, bus.clr_en, bus.disp_valid, done}), 32'd0);
          if (k == 0) begin
            chk("rd_addr1", 32'(bus.rd_addr1), 32'((op == 3'd7) ? a : b));
            chk("rd_addr2", 32'(bus.rd_addr2), 32'(c));
          end
        end else if (k == lat) begin
          chk("busy_strobe", 32'(busy), 32'd1);
          chk("done", 32'(done), 32'd1);
          chk("wr_en", 32'(bus.wr_en), 32'(kind == 0));
          chk("clr_en", 32'(bus.clr_en), 32'(kind == 1));
          chk("disp_valid", 32'(bus.disp_valid), 32'(kind == 2));
          chk("wr_addr", 32'(bus.wr_addr), (kind == 0) ? 32'(a) : 32'd0);
          chk("wr_data", 32'(bus.wr_data), (kind == 0) ? 32'(exp_data) : 32'd0);
          chk("disp_addr", 32'(bus.disp_addr), (kind == 2) ? 32'(a) : 32'd0);
          chk("disp_value", 32'(bus.disp_value), 32'(m_disp));
          chk("ovf", 32'(ovf), 32'(m_ovf));
          last_data = (kind == 2) ? bus.disp_value : bus.wr_data;
          last_ovf  = ovf;
        end else begin
          chk("busy_post", 32'(busy), 32'd0);
          chk("strobe_post", 32'({bus.wr_en, bus.clr_en, bus.disp_valid, done}), 32'd0);
        end
        if (k <= lat) @(negedge clk);
      end
    end
    repeat (hold) @(negedge clk);
    send = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_count", 32'(n_done - done0), 32'd1);
    chk("strobe_count", 32'(n_strobe - strobe0), 32'd1);
    chk("disp_hold", 32'(bus.disp_value), 32'(m_disp));
    chk("ovf_hold", 32'(ovf), 32'(m_ovf));
    if (kind == 0) chk("ram_write", 32'(ram[a]), 32'(exp_data));
    if (kind == 1) begin
      orv = 1'b0;
      for (int i = 0; i < 16; i++) orv = orv | (|ram[i]);
      chk("ram_clear", 32'(orv), 32'd0);
    end
  endtask

  task automatic reset_abort();
    int t, done0, strobe0;
    logic [15:0] old2;
    ram_poke(4'd3, 16'h0123);
    ram_poke(4'd4, 16'h0456);
    old2 = ram[2];
    done0 = n_done; strobe0 = n_strobe;
    @(negedge clk);
    instr = 16'h2468; send = 1'b1;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk); t++;
    end
    chk("abort_accept", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1; send = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_strobes", 32'({bus.wr_en, bus.clr_en, bus.disp_valid, done}), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_disp", 32'(bus.disp_value), 32'd0);
    chk("abort_bus", 32'({bus.rd_addr1, bus.rd_addr2, bus.wr_addr, bus.disp_addr}), 32'd0);
    chk("abort_wr_data", 32'(bus.wr_data), 32'd0);
    m_ovf = 1'b0; m_disp = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(n_done - done0), 32'd0);
    chk("abort_no_strobe", 32'(n_strobe - strobe0), 32'd0);
    chk("abort_ram", 32'(ram[2]), 32'(old2));
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; instr = 16'h0;
    bd_en = 1'b0; bd_addr = 4'h0; bd_data = 16'h0;
    m_ovf = 1'b0; m_disp = 16'h0; last_data = 16'h0; last_ovf = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({bus.wr_en, bus.clr_en, bus.disp_valid, done}), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_disp", 32'(bus.disp_value), 32'd0);
    chk("rst_bus", 32'({bus.rd_addr1, bus.rd_addr2, bus.wr_addr, bus.disp_addr}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_instr(16'h06FF, 1'b0, 2);
    chk("plan_load", 32'(last_data), 32'h00FF);
    ram_poke(4'd3, 16'h7FFF);
    ram_poke(4'd4, 16'h0001);
    run_instr(16'h2468, 1'b0, 2);
    chk("plan_add", 32'({last_ovf, last_data}), 32'h18000);
    ram_poke(4'd1, 16'h0005);
    run_instr(16'h823F, 1'b0, 2);
    chk("plan_subi", 32'({last_ovf, last_data}), 32'h00006);
    ram_poke(4'd5, 16'h4000);
    run_instr(16'hA0A2, 1'b0, 2);
    chk("plan_mul", 32'({last_ovf, last_data}), 32'h18000);
    ram_poke(4'd7, 16'h1234);
    run_instr(16'hEE00, 1'b0, 100);
    chk("plan_disp", 32'(last_data), 32'h1234);
    run_instr(16'h2468, 1'b1, 100);
    run_instr(16'hC000, 1'b0, 2);
    reset_abort();

    for (int i = 0; i < 16; i++) ram_poke(4'(i), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        ram_poke(4'($urandom), ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000);
      run_instr(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
